// File: rtl/mips_pkg.sv
// Shared constants and types for the EX-stage multiply/divide unit.
package mips_pkg;

  localparam int unsigned WIDTH = 32;

  // Count loaded at accept; RUN iterates while counting down to zero (32 steps).
  localparam logic [4:0] ITER_LAST = 5'd31;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate.
module muldiv_negate #(
  parameter int unsigned Width = 64
) (
  input  logic [Width-1:0] data,
  input  logic             neg,
  output logic [Width-1:0] result
);

  assign result = neg ? (~data + Width'(1)) : data;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; fixed 33-cycle latency, stalls while busy.
module ex_muldiv_unit
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             In_Start,
  input  logic [1:0]       In_Op,
  input  logic [WIDTH-1:0] In_Reg_File_Data1,
  input  logic [WIDTH-1:0] In_Reg_File_Data2,
  input  logic             In_Flush,
  input  logic             In_HI_Write,
  input  logic             In_LO_Write,
  input  logic [WIDTH-1:0] In_Write_Data,
  output logic [WIDTH-1:0] Out_HI,
  output logic [WIDTH-1:0] Out_LO,
  output logic             Out_Busy,
  output logic             Out_Done,
  output logic             Out_Div_By_Zero
);

  state_e             state_q;
  logic [1:0]         op_q;
  logic [4:0]         count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic               sign_q;
  logic               rsign_q;
  logic               zero_div_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               dbz_q;

  logic               idle;
  logic               in_signed;
  logic               in_div;
  logic [2*WIDTH-1:0] wide_in;
  logic [2*WIDTH-1:0] wide_out;
  logic               wide_neg;
  logic [WIDTH-1:0]   narrow_in;
  logic [WIDTH-1:0]   narrow_out;
  logic               narrow_neg;

  assign idle      = (state_q == IDLE);
  assign in_signed = ~In_Op[0];
  assign in_div    = In_Op[1];

  // Negators are shared: operand magnitudes in IDLE, result sign fix-up in FIX.
  always_comb begin
    wide_in    = acc_q;
    wide_neg   = sign_q;
    narrow_in  = acc_q[2*WIDTH-1:WIDTH];
    narrow_neg = rsign_q;
    if (idle) begin
      wide_in    = {{WIDTH{In_Reg_File_Data1[WIDTH-1]}}, In_Reg_File_Data1};
      wide_neg   = in_signed & In_Reg_File_Data1[WIDTH-1];
      narrow_in  = In_Reg_File_Data2;
      narrow_neg = in_signed & In_Reg_File_Data2[WIDTH-1];
    end
  end

  muldiv_negate #(
    .Width (2 * WIDTH)
  ) u_neg_wide (
    .data   (wide_in),
    .neg    (wide_neg),
    .result (wide_out)
  );

  muldiv_negate #(
    .Width (WIDTH)
  ) u_neg_narrow (
    .data   (narrow_in),
    .neg    (narrow_neg),
    .result (narrow_out)
  );

  // Multiply: add multiplicand into the upper half when the multiplier LSB is set, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  // Divide: shift remainder left, restoring subtract of the divisor.
  logic [WIDTH:0]     div_part;
  logic [WIDTH-1:0]   div_diff;
  logic               div_borrow;
  logic               div_fits;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    div_part                 = acc_q[2*WIDTH-1:WIDTH-1];
    {div_borrow, div_diff}   = {1'b0, div_part[WIDTH-1:0]} - {1'b0, opb_q};
    // A set bit 32 means the partial remainder exceeds any 32-bit divisor.
    div_fits                 = div_part[WIDTH] | ~div_borrow;
    div_next = div_fits ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                        : {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= OP_MULT;
      count_q    <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      sign_q     <= 1'b0;
      rsign_q    <= 1'b0;
      zero_div_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (In_Start && !In_Flush) begin
            op_q       <= In_Op;
            count_q    <= ITER_LAST;
            sign_q     <= in_signed & (In_Reg_File_Data1[WIDTH-1] ^ In_Reg_File_Data2[WIDTH-1]);
            rsign_q    <= in_signed & In_Reg_File_Data1[WIDTH-1];
            zero_div_q <= in_div & (In_Reg_File_Data2 == '0);
            dbz_q      <= 1'b0;
            if (in_div) begin
              acc_q <= {{WIDTH{1'b0}}, wide_out[WIDTH-1:0]};
              opb_q <= narrow_out;
            end else begin
              acc_q <= {{WIDTH{1'b0}}, narrow_out};
              opb_q <= wide_out[WIDTH-1:0];
            end
            state_q <= RUN;
          end else if (!In_Start) begin
            if (In_HI_Write) hi_q <= In_Write_Data;
            if (In_LO_Write) lo_q <= In_Write_Data;
          end
        end
        RUN: begin
          if (In_Flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= op_q[1] ? div_next : mul_next;
            if (count_q == '0) state_q <= FIX;
            else               count_q <= count_q - 5'd1;
          end
        end
        FIX: begin
          if (In_Flush) begin
            state_q <= IDLE;
          end else begin
            if (op_q[1]) begin
              lo_q <= zero_div_q ? '1 : wide_out[WIDTH-1:0];
              hi_q <= narrow_out;
            end else begin
              {hi_q, lo_q} <= wide_out;
            end
            dbz_q   <= zero_div_q;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Out_HI          = hi_q;
  assign Out_LO          = lo_q;
  assign Out_Busy        = ~idle;
  assign Out_Done        = done_q;
  assign Out_Div_By_Zero = dbz_q;

endmodule
